// File: rtl/sort_result_serializer_pkg.sv
// sort_result_serializer_pkg
//   Shared definitions for the sort result serializer slice:
//   array depth/element width, index width, one-hot FSM state encoding
//   and the packed-array element selector used by sort_elem_mux.
package sort_result_serializer_pkg;

  localparam int unsigned N     = 30;  // array depth, must match the sorter
  localparam int unsigned W     = 7;   // element width in bits
  localparam int unsigned IDX_W = 5;   // width of index / count / width fields

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_SEND = 4'b0010,
    S_ACK  = 4'b0100,
    S_WAIT = 4'b1000
  } state_e;

  // Element idx of a packed array (element i at [i*W +: W]).
  // Indices at or beyond N return zero.
  function automatic logic [W-1:0] sort_slice(input logic [N*W-1:0]   arr,
                                              input logic [IDX_W-1:0] idx);
    logic [W-1:0] e;
    e = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) e = arr[k*W +: W];
    end
    return e;
  endfunction

endpackage

// File: rtl/sort_elem_mux.sv
// sort_elem_mux
//   Combinational N:1 selector of one W-bit element from a packed array.
//   Ports:
//     arr_i  [N*W] packed array, element i at [i*W +: W]
//     idx_i  [5]   element index (out-of-range -> 0)
//     elem_o [W]   selected element
module sort_elem_mux
  import sort_result_serializer_pkg::*;
(
  input  logic [N*W-1:0]   arr_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [W-1:0]     elem_o
);

  always_comb elem_o = sort_slice(arr_i, idx_i);

endmodule

// File: rtl/sort_result_serializer.sv
// sort_result_serializer
//   Captures the insertion sorter's packed result array and element count
//   when Done is seen in IDLE, streams the first min(width, N) elements over
//   a valid/ready interface, pulses Ack for one cycle, then waits for Done to
//   fall before accepting a new batch.
//
//   Optional feature macro: SORT_SER_DEDUP_EN
//     Defined   : duplicate elements of the (sorted) array are skipped with a
//                 one-cycle bubble each; Count reports distinct values sent.
//     Undefined : every element is sent; no compare logic is built.
//
//   Ports:
//     Clk, Reset       clock (rising edge), synchronous active-high reset
//     width      [5]   element count, sampled at capture
//     Done             sorter result-ready level
//     Ain        [N*W] sorter packed output, element i at [i*W +: W]
//     Ack              one-cycle pulse after the batch is fully sent
//     Dout       [W]   current element (registered)
//     Dout_valid       Dout is valid (registered)
//     Dout_ready       consumer accepts when valid && ready
//     Dout_last        current element is the final one of the batch
//     Count      [5]   elements transferred in the current/last batch
//     q_Idle/q_Send/q_Ack/q_Wait  one-hot state taps
module sort_result_serializer
  import sort_result_serializer_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       width,
  input  logic             Done,
  input  logic [N*W-1:0]   Ain,
  output logic             Ack,
  output logic [W-1:0]     Dout,
  output logic             Dout_valid,
  input  logic             Dout_ready,
  output logic             Dout_last,
  output logic [4:0]       Count,
  output logic             q_Idle,
  output logic             q_Send,
  output logic             q_Ack,
  output logic             q_Wait
);

  state_e             state_q;
  logic [N*W-1:0]     arr_q;
  logic [IDX_W-1:0]   w_q;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       dout_q;
  logic               valid_q;
  logic               last_q;
  logic               ack_q;
  logic [IDX_W-1:0]   count_q;

  logic [IDX_W-1:0]   w_cap;
  logic               in_idle;
  logic [N*W-1:0]     src_arr;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   lim;
  logic [W-1:0]       nxt_elem;
  logic               nxt_last;
  logic               nxt_valid;
  logic               xfer;
  logic               advance;

  assign w_cap   = (width > IDX_W'(N)) ? IDX_W'(N) : width;
  assign in_idle = (state_q == S_IDLE);

  // The element mux looks at Ain while idle so that A[0] is on Dout the
  // cycle after capture; afterwards it looks at the captured copy and
  // pre-selects the element following the current one.
  assign src_arr = in_idle ? Ain : arr_q;
  assign sel_idx = in_idle ? '0 : idx_q + IDX_W'(1);
  assign lim     = in_idle ? w_cap : w_q;
  assign xfer    = valid_q & Dout_ready;

  sort_elem_mux u_elem (
    .arr_i  (src_arr),
    .idx_i  (sel_idx),
    .elem_o (nxt_elem)
  );

`ifdef SORT_SER_DEDUP_EN
  logic [IDX_W-1:0] tail_idx;
  logic [W-1:0]     tail_elem;

  assign tail_idx = lim - IDX_W'(1);

  sort_elem_mux u_tail (
    .arr_i  (src_arr),
    .idx_i  (tail_idx),
    .elem_o (tail_elem)
  );

  // Dout always holds the most recently transferred value when the next
  // element is loaded: after a transfer it is the sent value, and during a
  // bubble it is a duplicate of that value. No separate history register.
  assign nxt_valid = in_idle | (nxt_elem != dout_q);
  assign nxt_last  = (sel_idx == tail_idx) | (nxt_elem == tail_elem);
  assign advance   = xfer | ((state_q == S_SEND) & ~valid_q);
`else
  assign nxt_valid = 1'b1;
  assign nxt_last  = (sel_idx == lim - IDX_W'(1));
  assign advance   = xfer;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ack_q   <= 1'b0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Done) begin
            arr_q   <= Ain;
            w_q     <= w_cap;
            idx_q   <= '0;
            count_q <= '0;
            if (w_cap != '0) begin
              state_q <= S_SEND;
              dout_q  <= nxt_elem;
              valid_q <= nxt_valid;
              last_q  <= nxt_last;
            end else begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (advance) begin
            if (xfer) count_q <= count_q + IDX_W'(1);
            if (last_q) begin
              state_q <= S_ACK;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              ack_q   <= 1'b1;
            end else begin
              idx_q   <= sel_idx;
              dout_q  <= nxt_elem;
              valid_q <= nxt_valid;
              last_q  <= nxt_last;
            end
          end
        end
        S_ACK: begin
          ack_q   <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!Done) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign Ack        = ack_q;
  assign Dout       = dout_q;
  assign Dout_valid = valid_q;
  assign Dout_last  = last_q;
  assign Count      = count_q;
  assign q_Idle     = (state_q == S_IDLE);
  assign q_Send     = (state_q == S_SEND);
  assign q_Ack      = (state_q == S_ACK);
  assign q_Wait     = (state_q == S_WAIT);

endmodule

// File: tb/tb_sort_result_serializer.sv
// tb_sort_result_serializer
//   Directed self-checking bench for sort_result_serializer.
module tb_sort_result_serializer;
  import sort_result_serializer_pkg::*;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [4:0]     width;
  logic           Done;
  logic [N*W-1:0] Ain;
  logic           Ack;
  logic [W-1:0]   Dout;
  logic           Dout_valid;
  logic           Dout_ready;
  logic           Dout_last;
  logic [4:0]     Count;
  logic           q_Idle, q_Send, q_Ack, q_Wait;

  sort_result_serializer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .width      (width),
    .Done       (Done),
    .Ain        (Ain),
    .Ack        (Ack),
    .Dout       (Dout),
    .Dout_valid (Dout_valid),
    .Dout_ready (Dout_ready),
    .Dout_last  (Dout_last),
    .Count      (Count),
    .q_Idle     (q_Idle),
    .q_Send     (q_Send),
    .q_Ack      (q_Ack),
    .q_Wait     (q_Wait)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  int vec[$];     // values loaded into Ain, element 0 first
  int exp_q[$];   // expected transferred values
  int got[64];

  int res_nx, res_nlast, res_lastpos, res_gap, res_acklen, res_lastcyc, res_unstable;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_vec();
    logic [N*W-1:0] a;
    a = '0;
    foreach (vec[i]) a[i*W +: W] = W'(vec[i]);
    Ain = a;
  endtask

  // Streams one batch starting at the negedge after capture.
  // mode 0: ready held high; mode 1: ready 1,0,0 repeating.
  task automatic stream(input int mode);
    int   cyc       = 0;
    int   first_ack = -1;
    bit   held      = 0;
    logic [W-1:0] hv = '0;
    res_nx = 0; res_nlast = 0; res_lastpos = -1; res_acklen = 0;
    res_lastcyc = -1; res_unstable = 0;
    while (cyc < 100) begin
      Dout_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      #1;
      if (held && (!Dout_valid || Dout !== hv)) res_unstable++;
      held = 0;
      if (Dout_valid && Dout_ready) begin
        if (res_nx < 64) got[res_nx] = int'(Dout);
        if (Dout_last) begin
          res_nlast++;
          res_lastpos = res_nx;
        end
        res_nx++;
        res_lastcyc = cyc;
      end else if (Dout_valid) begin
        held = 1;
        hv   = Dout;
      end
      if (Ack) begin
        res_acklen++;
        if (first_ack < 0) first_ack = cyc;
      end else if (first_ack >= 0) begin
        break;
      end
      @(negedge Clk);
      cyc++;
    end
    res_gap = first_ack - res_lastcyc;
  endtask

  task automatic run_batch(input string tag, input int w, input int mode, input bit drop_done);
    load_vec();
    width      = 5'(w);
    Done       = 1'b1;
    Dout_ready = 1'b1;
    @(negedge Clk);
    check_eq({tag, "_first_valid"}, Dout_valid, 1);
    check_eq({tag, "_first_dout"}, Dout, exp_q[0]);
    if (drop_done) Done = 1'b0;
    stream(mode);
    check_eq({tag, "_ntransfers"}, res_nx, exp_q.size());
    foreach (exp_q[i]) check_eq($sformatf("%s_d%0d", tag, i), got[i], exp_q[i]);
    check_eq({tag, "_nlast"}, res_nlast, 1);
    check_eq({tag, "_lastpos"}, res_lastpos, exp_q.size() - 1);
    check_eq({tag, "_ack_gap"}, res_gap, 1);
    check_eq({tag, "_ack_len"}, res_acklen, 1);
    check_eq({tag, "_count"}, Count, exp_q.size());
    check_eq({tag, "_wait"}, q_Wait, 1);
  endtask

  task automatic end_batch(input string tag);
    Done = 1'b0;
    @(negedge Clk);
    check_eq({tag, "_idle"}, q_Idle, 1);
  endtask

  initial begin
    Reset = 1'b1; width = '0; Done = 1'b0; Ain = '0; Dout_ready = 1'b0;
    repeat (2) @(negedge Clk);
    check_eq("rst_idle",  q_Idle, 1);
    check_eq("rst_valid", Dout_valid, 0);
    check_eq("rst_ack",   Ack, 0);
    check_eq("rst_last",  Dout_last, 0);
    check_eq("rst_dout",  Dout, 0);
    check_eq("rst_count", Count, 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Five elements, ready high: back-to-back transfers.
    vec   = '{3, 9, 12, 40, 127};
    exp_q = '{3, 9, 12, 40, 127};
    run_batch("w5", 5, 0, 0);
    check_eq("w5_nobubble", res_lastcyc, 4);
    repeat (3) @(negedge Clk);
    check_eq("w5_hold_wait", q_Wait, 1);
    check_eq("w5_no_reack",  Ack, 0);
    end_batch("w5");

    // Width 0: no transfers, Ack straight after capture.
    width = 5'd0; Done = 1'b1;
    @(negedge Clk);
    check_eq("w0_ack_state", q_Ack, 1);
    check_eq("w0_ack",       Ack, 1);
    check_eq("w0_valid",     Dout_valid, 0);
    @(negedge Clk);
    check_eq("w0_ack_drop",  Ack, 0);
    check_eq("w0_wait",      q_Wait, 1);
    @(negedge Clk);
    check_eq("w0_wait_hold", q_Wait, 1);
    check_eq("w0_count",     Count, 0);
    end_batch("w0");

    // Width 31 clamps to 30.
    vec.delete(); exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      vec.push_back((i * 4 + 1) % 128);
      exp_q.push_back((i * 4 + 1) % 128);
    end
    run_batch("w31", 31, 0, 0);
    end_batch("w31");

    // Ready toggling, Done dropped during SEND.
    vec   = '{1, 2, 3, 4};
    exp_q = '{1, 2, 3, 4};
    run_batch("rdy", 4, 1, 1);
    check_eq("rdy_stable", res_unstable, 0);
    end_batch("rdy");

    // Duplicate handling.
    vec = '{5, 5, 7, 7, 7, 9};
`ifdef SORT_SER_DEDUP_EN
    exp_q = '{5, 7, 9};
`else
    exp_q = '{5, 5, 7, 7, 7, 9};
`endif
    run_batch("dup6", 6, 0, 0);
    end_batch("dup6");

    vec = '{4, 8, 8, 8};
`ifdef SORT_SER_DEDUP_EN
    exp_q = '{4, 8};
`else
    exp_q = '{4, 8, 8, 8};
`endif
    run_batch("dup4", 4, 0, 0);
    end_batch("dup4");

    // Reset mid-SEND after two transfers.
    vec = '{3, 9, 12, 40, 127};
    load_vec();
    width = 5'd5; Done = 1'b1; Dout_ready = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Done = 1'b0;
    @(negedge Clk);
    check_eq("mid_count", Count, 2);
    check_eq("mid_dout",  Dout, 12);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_eq("mrst_idle",  q_Idle, 1);
    check_eq("mrst_valid", Dout_valid, 0);
    check_eq("mrst_ack",   Ack, 0);
    check_eq("mrst_count", Count, 0);
    @(negedge Clk);
    check_eq("mrst_ack2",  Ack, 0);
    check_eq("mrst_idle2", q_Idle, 1);

    // Done still high across reset triggers a fresh capture.
    vec = '{21, 22};
    load_vec();
    width = 5'd2; Done = 1'b1; Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_eq("rcap_idle", q_Idle, 1);
    @(negedge Clk);
    check_eq("rcap_valid", Dout_valid, 1);
    check_eq("rcap_dout",  Dout, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
